// File: rtl/sensor_conditioner_if.sv
// Raw beam-sensor levels in, conditioned levels and event pulses out.
interface sensor_conditioner_if;
  logic a_raw;
  logic b_raw;
  logic a;
  logic b;
  logic a_rise;
  logic a_fall;
  logic b_rise;
  logic b_fall;
  logic skip;

  modport master (
    output a_raw, b_raw,
    input  a, b, a_rise, a_fall, b_rise, b_fall, skip
  );

  modport slave (
    input  a_raw, b_raw,
    output a, b, a_rise, a_fall, b_rise, b_fall, skip
  );
endinterface

// File: rtl/sensor_conditioner.sv
// Two-channel synchronizer + debouncer for the parking-lot beam sensors, with edge and skip pulses.
// A stable raw change shows on a/b at the (DEBOUNCE+2)th edge; free-running, no backpressure.
module sensor_conditioner #(
  parameter int  DEBOUNCE = 4,
  localparam int CW       = $clog2(DEBOUNCE + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  sensor_conditioner_if.slave  sif
);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  // Bit 0 is channel a, bit 1 is channel b throughout.
  logic [1:0]         s1_q, s1_d;
  logic [1:0]         s2_q, s2_d;
  logic [1:0]         lvl_q, lvl_d;
  logic [1:0]         rise_q, rise_d;
  logic [1:0]         fall_q, fall_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic               skip_q, skip_d;
  logic [1:0]         acc;

  always_comb begin
    s1_d  = {sif.b_raw, sif.a_raw};
    s2_d  = s1_q;
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    acc   = '0;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == LAST) begin
        lvl_d[i] = s2_q[i];
        cnt_d[i] = '0;
        acc[i]   = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    rise_d = acc & lvl_d;
    fall_d = acc & ~lvl_d;
    skip_d = &acc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      lvl_q  <= '0;
      cnt_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      skip_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      lvl_q  <= lvl_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      skip_q <= skip_d;
    end
  end

  assign sif.a      = lvl_q[0];
  assign sif.b      = lvl_q[1];
  assign sif.a_rise = rise_q[0];
  assign sif.a_fall = fall_q[0];
  assign sif.b_rise = rise_q[1];
  assign sif.b_fall = fall_q[1];
  assign sif.skip   = skip_q;
endmodule

// File: tb/tb_sensor_conditioner.sv
// Randomized and directed bench for sensor_conditioner against a sample-window reference model.
module tb_sensor_conditioner;
  localparam int D = 4;

  logic clk;
  logic reset;
  int   checks = 0;
  int   fails  = 0;

  sensor_conditioner_if sif();

  sensor_conditioner #(.DEBOUNCE(D)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  // Model: a level is accepted once the last D synchronized samples all agree and differ from it.
  bit [1:0] hist[$];
  bit [1:0] mx;
  bit [1:0] m_rise;
  bit [1:0] m_fall;
  bit       m_skip;

  always @(posedge clk or negedge reset) begin
    bit [1:0] acc;
    bit       v;
    bit       same;
    if (!reset) begin
      hist = {};
      for (int i = 0; i < D + 2; i++) hist.push_front(2'b00);
      mx = 0; m_rise = 0; m_fall = 0; m_skip = 0;
    end else begin
      hist.push_front({sif.b_raw, sif.a_raw});
      if (hist.size() > D + 2) void'(hist.pop_back());
      acc = 0;
      for (int ch = 0; ch < 2; ch++) begin
        v    = hist[2][ch];
        same = 1;
        for (int j = 2; j < D + 2; j++) if (hist[j][ch] != v) same = 0;
        if (same && v != mx[ch]) begin
          acc[ch] = 1;
          mx[ch]  = v;
        end
      end
      m_rise = acc & mx;
      m_fall = acc & ~mx;
      m_skip = &acc;
    end
  end

  function automatic logic [6:0] model_vec();
    return {mx[0], mx[1], m_rise[0], m_fall[0], m_rise[1], m_fall[1], m_skip};
  endfunction

  function automatic logic [6:0] dut_vec();
    return {sif.a, sif.b, sif.a_rise, sif.a_fall, sif.b_rise, sif.b_fall, sif.skip};
  endfunction

  task automatic run_idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== model_vec()) begin
        fails++;
        $display("FAIL idle_model got=%b exp=%b t=%0t", dut_vec(), model_vec(), $time);
      end
    end
  endtask

  task automatic test_reset();
    sif.a_raw = 1'b1;
    sif.b_raw = 1'b1;
    reset = 1'b1;
    #10 reset = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== 7'b0) begin
      fails++;
      $display("FAIL reset_async got=%b exp=%b", dut_vec(), 7'b0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== 7'b0) begin
        fails++;
        $display("FAIL reset_held edge=%0d got=%b exp=%b", k + 1, dut_vec(), 7'b0);
      end
    end
    sif.a_raw = 1'b0;
    sif.b_raw = 1'b0;
    reset = 1'b1;
    run_idle(3);
  endtask

  task automatic test_a_rise();
    int rises = 0;
    sif.a_raw = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      rises += int'(sif.a_rise);
      checks++;
      if ({sif.a, sif.a_rise} !== {1'(k >= 6), 1'(k == 6)}) begin
        fails++;
        $display("FAIL a_rise_timing edge=%0d got=%b exp=%b", k, {sif.a, sif.a_rise}, {1'(k >= 6), 1'(k == 6)});
      end
      checks++;
      if ({sif.b, sif.b_rise, sif.b_fall, sif.skip, sif.a_fall} !== 5'b0) begin
        fails++;
        $display("FAIL a_rise_quiet edge=%0d got=%b exp=00000", k, {sif.b, sif.b_rise, sif.b_fall, sif.skip, sif.a_fall});
      end
    end
    checks++;
    if (rises != 1) begin
      fails++;
      $display("FAIL a_rise_count got=%0d exp=1", rises);
    end
  endtask

  task automatic test_glitch();
    int rises = 0;
    sif.a_raw = 1'b0;
    run_idle(8);
    sif.a_raw = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rises += int'(sif.a_rise);
    end
    sif.a_raw = 1'b0;
    @(negedge clk);
    rises += int'(sif.a_rise);
    sif.a_raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      rises += int'(sif.a_rise);
      checks++;
      if (sif.a !== 1'(k >= 6)) begin
        fails++;
        $display("FAIL glitch_level edge=%0d got=%b exp=%b", k, sif.a, 1'(k >= 6));
      end
    end
    checks++;
    if (rises != 1) begin
      fails++;
      $display("FAIL glitch_rise_count got=%0d exp=1", rises);
    end
  endtask

  task automatic test_simultaneous();
    sif.a_raw = 1'b0;
    sif.b_raw = 1'b0;
    run_idle(8);
    sif.a_raw = 1'b1;
    sif.b_raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== {1'(k >= 6), 1'(k >= 6), 1'(k == 6), 1'b0, 1'(k == 6), 1'b0, 1'(k == 6)}) begin
        fails++;
        $display("FAIL simul_edge edge=%0d got=%b exp=%b", k, dut_vec(),
                 {1'(k >= 6), 1'(k >= 6), 1'(k == 6), 1'b0, 1'(k == 6), 1'b0, 1'(k == 6)});
      end
    end
  endtask

  task automatic test_bounce_b();
    int b_rises = 0;
    sif.b_raw = 1'b0;
    run_idle(8);
    sif.b_raw = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 2) sif.b_raw = 1'b0;
      @(negedge clk);
      b_rises += int'(sif.b_rise);
      checks++;
      if ({sif.a, sif.b} !== 2'b10) begin
        fails++;
        $display("FAIL bounce_b_level cyc=%0d got=%b exp=10", k, {sif.a, sif.b});
      end
    end
    checks++;
    if (b_rises != 0) begin
      fails++;
      $display("FAIL bounce_b_rises got=%0d exp=0", b_rises);
    end
    sif.a_raw = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if ({sif.a, sif.a_fall} !== {1'(k < 6), 1'(k == 6)}) begin
        fails++;
        $display("FAIL a_fall_timing edge=%0d got=%b exp=%b", k, {sif.a, sif.a_fall}, {1'(k < 6), 1'(k == 6)});
      end
    end
  endtask

  task automatic test_reset_mid_count();
    sif.a_raw = 1'b1;
    for (int k = 0; k < 3; k++) @(negedge clk);
    #10 reset = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== 7'b0) begin
      fails++;
      $display("FAIL midreset_async got=%b exp=%b", dut_vec(), 7'b0);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if ({sif.a, sif.a_rise} !== {1'(k >= 6), 1'(k == 6)}) begin
        fails++;
        $display("FAIL midreset_restart edge=%0d got=%b exp=%b", k, {sif.a, sif.a_rise}, {1'(k >= 6), 1'(k == 6)});
      end
    end
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 150; seg++) begin
      sif.a_raw = 1'($urandom_range(0, 1));
      sif.b_raw = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 8);
      if ($urandom_range(0, 39) == 0) begin
        #10 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        checks++;
        if (dut_vec() !== model_vec()) begin
          fails++;
          $display("FAIL random_model seg=%0d got=%b exp=%b t=%0t", seg, dut_vec(), model_vec(), $time);
        end
        checks++;
        if ((sif.a_rise & sif.a_fall) !== 1'b0 || (sif.b_rise & sif.b_fall) !== 1'b0) begin
          fails++;
          $display("FAIL random_both_edges got=%b exp=0000", {sif.a_rise, sif.a_fall, sif.b_rise, sif.b_fall});
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_a_rise();
    test_glitch();
    test_simultaneous();
    test_bounce_b();
    test_reset_mid_count();
    test_random();
    run_idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
